// File: rtl/screen_sequencer_if.sv
// Pin bundle between the game-flow sequencer, its layer renderers and the VGA pins.
// time_left exists only when SCREEN_SEQ_ROUND_TIMER_EN is defined.
interface screen_sequencer_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        start_key;
    logic        p1_hp_zero;
    logic        p2_hp_zero;
    logic [11:0] title_rgb;
    logic [11:0] fight_rgb;
    logic [11:0] over_rgb;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [2:0]  state;
    logic        game_active;
    logic [1:0]  winner;
`ifdef SCREEN_SEQ_ROUND_TIMER_EN
    logic [6:0]  time_left;

    modport master (
        output DrawX, DrawY, blank, start_key, p1_hp_zero, p2_hp_zero,
        output title_rgb, fight_rgb, over_rgb,
        input  red, green, blue, state, game_active, winner, time_left
    );
    modport slave (
        input  DrawX, DrawY, blank, start_key, p1_hp_zero, p2_hp_zero,
        input  title_rgb, fight_rgb, over_rgb,
        output red, green, blue, state, game_active, winner, time_left
    );
`else
    modport master (
        output DrawX, DrawY, blank, start_key, p1_hp_zero, p2_hp_zero,
        output title_rgb, fight_rgb, over_rgb,
        input  red, green, blue, state, game_active, winner
    );
    modport slave (
        input  DrawX, DrawY, blank, start_key, p1_hp_zero, p2_hp_zero,
        input  title_rgb, fight_rgb, over_rgb,
        output red, green, blue, state, game_active, winner
    );
`endif
endinterface

// File: rtl/screen_sequencer.sv
// Game-flow controller: picks title/fight/game-over layer, runs frame-counted fades, tracks winner.
// Optional round timer enabled by defining SCREEN_SEQ_ROUND_TIMER_EN.
module screen_sequencer #(
    parameter int unsigned FADE_FRAMES    = 2,
    parameter int unsigned KO_FRAMES      = 120,
    parameter int unsigned FRAME_LINE     = 480
`ifdef SCREEN_SEQ_ROUND_TIMER_EN
    ,
    parameter int unsigned ROUND_SECONDS  = 99,
    parameter int unsigned FRAMES_PER_SEC = 60
`endif
) (
    input  logic               vga_clk,
    input  logic               reset,
    screen_sequencer_if.slave  bus
);
    localparam int unsigned CNT_MAX = (KO_FRAMES > FADE_FRAMES) ? KO_FRAMES : FADE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_TITLE    = 3'd0,
        S_FADE_OUT = 3'd1,
        S_FADE_IN  = 3'd2,
        S_FIGHT    = 3'd3,
        S_KO       = 3'd4,
        S_OVER     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'd0,
        SCR_FIGHT = 2'd1,
        SCR_OVER  = 2'd2
    } screen_t;

    state_t             st;
    screen_t            cur_screen;
    screen_t            next_screen;
    logic [3:0]         level;
    logic [CNT_W-1:0]   fcnt;
    logic               start_key_q;
    logic [1:0]         winner;
    logic               game_active;
    logic               frame_tick_c;
    logic               start_rise_c;
    logic [11:0]        src_c;

`ifdef SCREEN_SEQ_ROUND_TIMER_EN
    localparam int unsigned SEC_W = $clog2(FRAMES_PER_SEC) + 1;
    logic [SEC_W-1:0]   sec_cnt;
    logic [6:0]         time_left;
    assign bus.time_left = time_left;
`endif

    assign frame_tick_c    = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(FRAME_LINE));
    assign start_rise_c    = bus.start_key & ~start_key_q;
    assign bus.state       = st;
    assign bus.winner      = winner;
    assign bus.game_active = game_active;

    // Game-flow FSM; fcnt counts frame ticks within fades and KO
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            st          <= S_TITLE;
            cur_screen  <= SCR_TITLE;
            next_screen <= SCR_TITLE;
            level       <= 4'd15;
            fcnt        <= '0;
            start_key_q <= 1'b0;
            winner      <= 2'd0;
            game_active <= 1'b0;
`ifdef SCREEN_SEQ_ROUND_TIMER_EN
            sec_cnt     <= '0;
            time_left   <= 7'(ROUND_SECONDS);
`endif
        end else begin
            start_key_q <= bus.start_key;
            case (st)
                S_TITLE: begin
                    if (start_rise_c) begin
                        next_screen <= SCR_FIGHT;
                        fcnt        <= '0;
                        st          <= S_FADE_OUT;
                    end
                end
                S_FADE_OUT: begin
                    if (frame_tick_c) begin
                        if (fcnt == CNT_W'(FADE_FRAMES - 1)) begin
                            fcnt <= '0;
                            if (level == 4'd0) begin
                                cur_screen <= next_screen;
                                st         <= S_FADE_IN;
                            end else begin
                                level <= level - 4'd1;
                            end
                        end else begin
                            fcnt <= fcnt + CNT_W'(1);
                        end
                    end
                end
                S_FADE_IN: begin
                    if (frame_tick_c) begin
                        if (fcnt == CNT_W'(FADE_FRAMES - 1)) begin
                            fcnt <= '0;
                            if (level == 4'd15) begin
                                case (cur_screen)
                                    SCR_FIGHT: begin
                                        st          <= S_FIGHT;
                                        game_active <= 1'b1;
                                        winner      <= 2'd0;
`ifdef SCREEN_SEQ_ROUND_TIMER_EN
                                        time_left   <= 7'(ROUND_SECONDS);
                                        sec_cnt     <= '0;
`endif
                                    end
                                    SCR_OVER: st <= S_OVER;
                                    default:  st <= S_TITLE;
                                endcase
                            end else begin
                                level <= level + 4'd1;
                            end
                        end else begin
                            fcnt <= fcnt + CNT_W'(1);
                        end
                    end
                end
                S_FIGHT: begin
                    // {p2,p1} maps directly onto 1 = P1 out, 2 = P2 out, 3 = draw
                    if (bus.p1_hp_zero || bus.p2_hp_zero) begin
                        winner      <= {bus.p2_hp_zero, bus.p1_hp_zero};
                        game_active <= 1'b0;
                        fcnt        <= '0;
                        st          <= S_KO;
                    end
`ifdef SCREEN_SEQ_ROUND_TIMER_EN
                    else if (time_left == 7'd0) begin
                        winner      <= 2'd3;
                        game_active <= 1'b0;
                        fcnt        <= '0;
                        st          <= S_KO;
                    end else if (frame_tick_c) begin
                        if (sec_cnt == SEC_W'(FRAMES_PER_SEC - 1)) begin
                            sec_cnt   <= '0;
                            time_left <= time_left - 7'd1;
                        end else begin
                            sec_cnt <= sec_cnt + SEC_W'(1);
                        end
                    end
`endif
                end
                S_KO: begin
                    if (frame_tick_c) begin
                        if (fcnt == CNT_W'(KO_FRAMES - 1)) begin
                            fcnt        <= '0;
                            next_screen <= SCR_OVER;
                            st          <= S_FADE_OUT;
                        end else begin
                            fcnt <= fcnt + CNT_W'(1);
                        end
                    end
                end
                S_OVER: begin
                    if (start_rise_c) begin
                        next_screen <= SCR_TITLE;
                        fcnt        <= '0;
                        st          <= S_FADE_OUT;
                    end
                end
                default: st <= S_TITLE;
            endcase
        end
    end

    always_comb begin
        src_c = bus.title_rgb;
        case (cur_screen)
            SCR_FIGHT: src_c = bus.fight_rgb;
            SCR_OVER:  src_c = bus.over_rgb;
            default:   src_c = bus.title_rgb;
        endcase
    end

    function automatic logic [3:0] scale(input logic [3:0] ch, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = 8'(ch) * (8'(lvl) + 8'd1);
        return 4'(prod >> 4);
    endfunction

    // Brightness-scaled, blank-gated pixel registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            bus.red   <= 4'd0;
            bus.green <= 4'd0;
            bus.blue  <= 4'd0;
        end else if (!bus.blank) begin
            bus.red   <= 4'd0;
            bus.green <= 4'd0;
            bus.blue  <= 4'd0;
        end else begin
            bus.red   <= scale(src_c[11:8], level);
            bus.green <= scale(src_c[7:4], level);
            bus.blue  <= scale(src_c[3:0], level);
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Randomised bench for screen_sequencer with a phase/tick-count reference model and literal spot checks.
module tb_screen_sequencer;
    localparam int FADE_FRAMES = 2;
    localparam int KO_FRAMES   = 120;
    localparam int FRAME_LINE  = 480;
    localparam int PH_TITLE = 0, PH_FADE_OUT = 1, PH_FADE_IN = 2, PH_FIGHT = 3, PH_KO = 4, PH_OVER = 5;
    localparam int SCR_TITLE = 0, SCR_FIGHT = 1, SCR_OVER = 2;

    logic vga_clk = 1'b0;
    logic reset;
    screen_sequencer_if bus();

    screen_sequencer #(
        .FADE_FRAMES(FADE_FRAMES),
        .KO_FRAMES  (KO_FRAMES),
        .FRAME_LINE (FRAME_LINE)
    ) dut (
        .vga_clk(vga_clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks, n_errors;
    int m_phase, m_ticks, m_cur, m_next, m_win;
    bit m_prev_key;
    int exp_r, exp_g, exp_b;
    bit cmp_en;
    int tick_pct, hp_pct, key_mode;
    int budget, ko_ticks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL timeout waiting for %s at %0t", nm, $time);
    endtask

    function automatic int model_level();
        if (m_phase == PH_FADE_OUT) return 15 - m_ticks / FADE_FRAMES;
        if (m_phase == PH_FADE_IN)  return m_ticks / FADE_FRAMES;
        return 15;
    endfunction

    task automatic model_reset();
        m_phase = PH_TITLE; m_ticks = 0; m_cur = SCR_TITLE; m_next = SCR_TITLE;
        m_win = 0; m_prev_key = 1'b0; exp_r = 0; exp_g = 0; exp_b = 0;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_ticks = 0;
    endtask

    // Advance the reference by one clock using the inputs the DUT just sampled
    task automatic model_step();
        logic [11:0] src;
        int lvl;
        bit tick, rise;
        if (reset) begin
            model_reset();
            return;
        end
        lvl = model_level();
        src = (m_cur == SCR_FIGHT) ? bus.fight_rgb : (m_cur == SCR_OVER) ? bus.over_rgb : bus.title_rgb;
        exp_r = bus.blank ? (int'(src[11:8]) * (lvl + 1)) / 16 : 0;
        exp_g = bus.blank ? (int'(src[7:4])  * (lvl + 1)) / 16 : 0;
        exp_b = bus.blank ? (int'(src[3:0])  * (lvl + 1)) / 16 : 0;
        tick = (bus.DrawX == 10'd0) && (int'(bus.DrawY) == FRAME_LINE);
        rise = bus.start_key && !m_prev_key;
        m_prev_key = bus.start_key;
        case (m_phase)
            PH_TITLE: if (rise) begin m_next = SCR_FIGHT; enter(PH_FADE_OUT); end
            PH_FADE_OUT: if (tick) begin
                m_ticks++;
                if (m_ticks == 16 * FADE_FRAMES) begin m_cur = m_next; enter(PH_FADE_IN); end
            end
            PH_FADE_IN: if (tick) begin
                m_ticks++;
                if (m_ticks == 16 * FADE_FRAMES) begin
                    if (m_cur == SCR_FIGHT) begin m_win = 0; enter(PH_FIGHT); end
                    else if (m_cur == SCR_OVER) enter(PH_OVER);
                    else enter(PH_TITLE);
                end
            end
            PH_FIGHT: if (bus.p1_hp_zero || bus.p2_hp_zero) begin
                if (bus.p1_hp_zero && bus.p2_hp_zero) m_win = 3;
                else if (bus.p1_hp_zero) m_win = 1;
                else m_win = 2;
                enter(PH_KO);
            end
            PH_KO: if (tick) begin
                m_ticks++;
                if (m_ticks == KO_FRAMES) begin m_next = SCR_OVER; enter(PH_FADE_OUT); end
            end
            PH_OVER: if (rise) begin m_next = SCR_TITLE; enter(PH_FADE_OUT); end
            default: ;
        endcase
    endtask

    task automatic cycle();
        @(posedge vga_clk);
        #1;
        model_step();
    endtask

    task automatic rand_drive();
        if (int'($urandom_range(99)) < tick_pct) begin
            bus.DrawX = 10'd0;
            bus.DrawY = 10'(FRAME_LINE);
        end else begin
            bus.DrawX = 10'($urandom_range(799));
            bus.DrawY = 10'($urandom_range(524));
        end
        bus.blank     = ($urandom_range(9) != 0);
        bus.title_rgb = 12'($urandom);
        bus.fight_rgb = 12'($urandom);
        bus.over_rgb  = 12'($urandom);
        if (key_mode == 1) bus.start_key = 1'b1;
        else if (key_mode == 0) bus.start_key = 1'b0;
        else if ($urandom_range(99) < 4) bus.start_key = ~bus.start_key;
        bus.p1_hp_zero = (int'($urandom_range(999)) < hp_pct);
        bus.p2_hp_zero = (int'($urandom_range(999)) < hp_pct);
    endtask

    task automatic quiet_inputs(input logic [11:0] rgb);
        bus.DrawX = 10'd3; bus.DrawY = 10'd7; bus.blank = 1'b1;
        bus.title_rgb = rgb; bus.fight_rgb = rgb; bus.over_rgb = rgb;
        bus.p1_hp_zero = 1'b0; bus.p2_hp_zero = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input string nm);
        budget = 6000;
        while (m_phase != ph && budget > 0) begin rand_drive(); cycle(); budget--; end
        if (budget == 0) timeout(nm);
    endtask

    task automatic wait_fade_out_level(input int lvl, input string nm);
        budget = 6000;
        while (!(m_phase == PH_FADE_OUT && model_level() == lvl) && budget > 0) begin
            rand_drive(); cycle(); budget--;
        end
        if (budget == 0) timeout(nm);
    endtask

    // Per-cycle comparison against the reference model
    always @(negedge vga_clk) begin
        if (cmp_en) begin
            chk("red", bus.red, exp_r);
            chk("green", bus.green, exp_g);
            chk("blue", bus.blue, exp_b);
            chk("state", bus.state, m_phase);
            chk("game_active", bus.game_active, (m_phase == PH_FIGHT) ? 1 : 0);
            chk("winner", bus.winner, m_win);
        end
    end

    initial begin
        n_checks = 0; n_errors = 0; cmp_en = 1'b0;
        tick_pct = 30; hp_pct = 0; key_mode = 0;
        reset = 1'b1;
        quiet_inputs(12'hF84);
        bus.start_key = 1'b0;
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_red", bus.red, 0);
        chk("reset_state", bus.state, 0);
        chk("reset_game_active", bus.game_active, 0);
        chk("reset_winner", bus.winner, 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        cycle();
        chk("title_red", bus.red, 4'hF);
        chk("title_green", bus.green, 4'h8);
        chk("title_blue", bus.blue, 4'h4);
        chk("title_state", bus.state, 0);

        bus.start_key = 1'b1;
        cycle();
        chk("start_fade_out", bus.state, 1);
        bus.start_key = 1'b0;

        wait_fade_out_level(7, "level7");
        quiet_inputs(12'hFFF);
        cycle();
        chk("lvl7_red", bus.red, 4'h7);
        chk("lvl7_green", bus.green, 4'h7);
        chk("lvl7_blue", bus.blue, 4'h7);
        bus.blank = 1'b0;
        cycle();
        chk("blank_red", bus.red, 0);
        chk("blank_blue", bus.blue, 0);

        wait_phase(PH_FIGHT, "fight");
        chk("fight_state", bus.state, 3);
        chk("fight_active", bus.game_active, 1);

        quiet_inputs(12'h123);
        bus.p1_hp_zero = 1'b1; bus.p2_hp_zero = 1'b1;
        cycle();
        chk("draw_winner", bus.winner, 3);
        chk("draw_state", bus.state, 4);
        chk("draw_active", bus.game_active, 0);

        ko_ticks = 0; budget = 4000;
        while (bus.state == 3'd4 && budget > 0) begin
            rand_drive();
            if (bus.DrawX == 10'd0 && int'(bus.DrawY) == FRAME_LINE) ko_ticks++;
            cycle(); budget--;
        end
        if (budget == 0) timeout("ko_end");
        chk("ko_frames", ko_ticks, KO_FRAMES);

        key_mode = 1;
        wait_phase(PH_OVER, "over");
        repeat (40) begin rand_drive(); cycle(); end
        chk("held_key_over", bus.state, 5);
        key_mode = 0;
        repeat (3) begin rand_drive(); cycle(); end
        key_mode = 1;
        rand_drive();
        cycle();
        chk("over_press", bus.state, 1);
        key_mode = 0;
        wait_phase(PH_TITLE, "back_to_title");
        chk("title_again", bus.state, 0);
        chk("winner_kept", bus.winner, 3);

        key_mode = 1; rand_drive(); cycle(); key_mode = 0;
        wait_fade_out_level(5, "level5");
        reset = 1'b1;
        model_reset();
        #1;
        chk("midfade_reset_state", bus.state, 0);
        chk("midfade_reset_red", bus.red, 0);
        chk("midfade_reset_green", bus.green, 0);
        quiet_inputs(12'hFFF);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        chk("post_reset_full_red", bus.red, 4'hF);
        chk("post_reset_state", bus.state, 0);

        key_mode = 2; hp_pct = 5;
        repeat (12000) begin
            rand_drive();
            cycle();
            if ($urandom_range(2999) == 0) begin
                reset = 1'b1;
                model_reset();
                cycle();
                reset = 1'b0;
            end
        end

        @(posedge vga_clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level game-flow controller for the VGA output path.
- Decides which full-screen layer drives the pixel outputs: title, fight or game-over.
- Sequences frame-counted fade-out/fade-in transitions between layers and tracks round outcome.
- Sits between the per-layer renderers (title ROM renderer, fight compositor, game-over renderer) and the VGA pins; all run on vga_clk.

Parameters:
- FADE_FRAMES, 2, frames per fade level step (16 levels per fade).
- KO_FRAMES, 120, frames held in KO before fading to game-over.
- FRAME_LINE, 480, DrawY value at which the frame tick fires (first blanked line).
- ROUND_SECONDS, 99, round timer start value (optional feature only).
- FRAMES_PER_SEC, 60, frame ticks per timer decrement (optional feature only).

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  asynchronous active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video, 0 = blanking.
- start_key  in  1  start button, level, synchronous to vga_clk.
- p1_hp_zero  in  1  player 1 health exhausted.
- p2_hp_zero  in  1  player 2 health exhausted.
- title_rgb  in  12  title layer pixel {r,g,b}.
- fight_rgb  in  12  fight layer pixel {r,g,b}.
- over_rgb  in  12  game-over layer pixel {r,g,b}.
- red  out  4  VGA red.
- green  out  4  VGA green.
- blue  out  4  VGA blue.
- state  out  3  encoded FSM state.
- game_active  out  1  1 only in FIGHT; enables player logic.
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw.

Behaviour:
- Reset (async): state=TITLE, cur_screen=title, next_screen=title, level=15, counters=0, winner=0, game_active=0, red/green/blue=0.
- frame_tick: 1-cycle pulse when DrawX==0 and DrawY==FRAME_LINE.
- start_rise: start_key registered once; start_rise = start_key & ~start_key_q. Only the rise is acted on, so a held key never retriggers.
- TITLE: start_rise -> next_screen=fight, go FADE_OUT.
- FADE_OUT:
  - Every FADE_FRAMES frame_ticks, decrement level.
  - On the step that would go below 0: cur_screen<=next_screen, level stays 0, go FADE_IN.
- FADE_IN:
  - Every FADE_FRAMES frame_ticks, increment level.
  - On reaching 15, go to the stable state for cur_screen: TITLE, FIGHT or OVER.
  - Entering FIGHT clears winner.
- FIGHT:
  - game_active=1.
  - Either hp_zero high -> winner = {p2_hp_zero & ~p1_hp_zero ? 2 : p1_hp_zero & ~p2_hp_zero ? 1 : 3}, go KO.
  - Both high in the same cycle -> winner=3 (draw).
- KO:
  - game_active=0, screen stays fight.
  - Count KO_FRAMES frame_ticks, then next_screen=over, go FADE_OUT.
- OVER: start_rise -> next_screen=title, go FADE_OUT.
- start_rise and hp_zero are ignored during fades and KO.
- Pixel path:
  - src = layer selected by cur_screen.
  - Each channel: out = (src_ch * (level+1)) >> 4, computed in 8 bits and truncated to 4. Level 15 passes src unchanged; level 0 gives black.
  - Outputs are registered on posedge vga_clk, 1-cycle latency from src and blank.
  - Output 0 on all channels when blank==0.
- Reset asserted mid-fade or mid-fight returns immediately to TITLE at full brightness.
- Frame counter width: ceil(log2(max(KO_FRAMES, FADE_FRAMES)))+1.

Optional Feature:
- Macro: SCREEN_SEQ_ROUND_TIMER_EN.
- Defined:
  - Adds output time_left[6:0].
  - time_left loads ROUND_SECONDS on entering FIGHT.
  - Decrements every FRAMES_PER_SEC frame_ticks while in FIGHT.
  - On reaching 0 with both players alive: winner=3, go KO.
  - hp_zero in the same cycle as expiry takes precedence.
  - Reset value is ROUND_SECONDS.
- Undefined: no port, no timer; rounds end only on hp_zero.

Test Plan:
- Reset, title_rgb=12'hF84, blank=1 -> one cycle later red/green/blue = F/8/4, state=TITLE.
- start_rise in TITLE, FADE_FRAMES=2 -> level falls 15..0 over 32 frames, then rises 0..15 over 32 frames on fight layer; state=FIGHT, game_active=1.
- Fade at level 7, src channel F -> output channel 7; blank=0 -> all outputs 0.
- p1_hp_zero and p2_hp_zero asserted in the same cycle in FIGHT -> winner=3, state=KO, game_active=0; after 120 frames, fade to OVER.
- start_key held high through FADE_IN into OVER -> no transition until released and pressed again; then fade back to TITLE.
- Reset asserted at level 5 mid-FADE_OUT -> next cycle state=TITLE, level=15, all outputs 0.
